// File: rtl/fir_seq_pkg.sv
// Shared state encoding and modulo-TAPS pointer helpers for the FIR MAC sequencer.
// Pointer math wraps at TAPS (not 2**AW) so non-power-of-two tap counts stay in range.
package fir_seq_pkg;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // Accumulator control word carried through the latency-matching delay: {acc_clr, acc_en}
  localparam int CTL_W = 2;

  function automatic int mod_inc(input int a, input int n);
    return (a + 1 >= n) ? 0 : a + 1;
  endfunction

  function automatic int mod_sub(input int a, input int b, input int n);
    return (a >= b) ? a - b : a + n - b;
  endfunction

endpackage

// File: rtl/fir_ctl_delay.sv
// Fixed-latency shift register that aligns accumulator strobes with the MAC datapath.
// Synchronous clear drops any strobes still in flight.
module fir_ctl_delay
  import fir_seq_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [CTL_W-1:0] i_dat,
  output logic [CTL_W-1:0] o_dat
);

  logic [CTL_W-1:0] r_stage [LAT];

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dat = r_stage[LAT-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Address/control sequencer for a time-multiplexed FIR: one sample write, TAPS tap reads,
// latency-matched accumulator strobes, then a held result under valid/ready.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS    = 8,
  parameter int AW      = 3,
  parameter int MAC_LAT = 2
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          smp_we,
  output logic          smp_zero,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          busy
);

  logic [2:0]       r_state;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_newest;
  logic [AW-1:0]    r_k;
  logic [2:0]       r_drain;
  logic [AW-1:0]    r_raddr;
  logic [AW-1:0]    r_coef;

  logic             w_in_clear;
  logic             w_in_idle;
  logic             w_in_mac;
  logic             w_in_hold;
  logic             w_last_tap;
  logic             w_drain_done;
  logic [AW-1:0]    w_k_inc;
  logic [AW-1:0]    w_wptr_inc;
  logic [AW-1:0]    w_raddr_next;
  logic [CTL_W-1:0] w_issue;
  logic [CTL_W-1:0] w_ctl_q;

  assign w_in_clear   = (r_state == ST_CLEAR);
  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_mac     = (r_state == ST_MAC);
  assign w_in_hold    = (r_state == ST_HOLD);
  assign w_last_tap   = (r_k == AW'(TAPS - 1));
  assign w_drain_done = (r_drain == 3'(MAC_LAT - 1));
  assign w_k_inc      = r_k + 1'b1;
  assign w_wptr_inc   = AW'(mod_inc(32'(r_wptr), TAPS));
  // Tap k reads the sample written k inputs ago: newest - k, wrapped at TAPS
  assign w_raddr_next = AW'(mod_sub(32'(r_newest), 32'(w_k_inc), TAPS));

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_wptr   <= '0;
      r_newest <= '0;
      r_k      <= '0;
      r_drain  <= '0;
      r_raddr  <= '0;
      r_coef   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (w_last_tap) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_wptr  <= '0;
          end else begin
            r_k <= w_k_inc;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            r_state  <= ST_MAC;
            r_newest <= r_wptr;
            r_wptr   <= w_wptr_inc;
            r_k      <= '0;
            r_coef   <= '0;
            r_raddr  <= r_wptr;
          end
        end
        ST_MAC: begin
          if (w_last_tap) begin
            r_state <= ST_DRAIN;
            r_k     <= '0;
            r_drain <= '0;
          end else begin
            r_k     <= w_k_inc;
            r_coef  <= w_k_inc;
            r_raddr <= w_raddr_next;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_HOLD;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_k     <= '0;
        end
      endcase
    end
  end

  assign w_issue = {w_in_mac & (r_k == '0), w_in_mac};

  fir_ctl_delay #(
    .LAT (MAC_LAT)
  ) u_ctl_delay (
    .CLK   (CLK),
    .rst   (rst),
    .i_dat (w_issue),
    .o_dat (w_ctl_q)
  );

  // Strobes are masked while rst is high so nothing leaks out during the reset cycle itself
  assign in_ready  = w_in_idle & ~rst;
  assign out_valid = w_in_hold & ~rst;
  assign smp_we    = ~rst & (w_in_clear | (w_in_idle & in_valid));
  assign smp_zero  = w_in_clear;
  assign smp_waddr = w_in_clear ? r_k : r_wptr;
  assign smp_raddr = r_raddr;
  assign coef_addr = r_coef;
  assign acc_en    = w_ctl_q[0] & ~rst;
  assign acc_clr   = w_ctl_q[1] & ~rst;
  assign busy      = ~w_in_idle;

  a_hold_stable: assert property (@(posedge CLK) disable iff (rst)
    (out_valid && !out_ready) |=> out_valid);
  a_clr_with_en: assert property (@(posedge CLK) disable iff (rst)
    acc_clr |-> acc_en);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed, table-driven bench for the FIR MAC sequencer (TAPS=8 and TAPS=5 instances).
module tb_fir_mac_sequencer;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst, in_valid, out_ready;
  logic       in_ready, out_valid, smp_we, smp_zero, acc_clr, acc_en, busy;
  logic [2:0] smp_waddr, smp_raddr, coef_addr;

  logic       rst_b, in_valid_b, out_ready_b;
  logic       in_ready_b, out_valid_b, smp_we_b, smp_zero_b, acc_clr_b, acc_en_b, busy_b;
  logic [2:0] smp_waddr_b, smp_raddr_b, coef_addr_b;

  fir_mac_sequencer #(.TAPS(8), .AW(3), .MAC_LAT(2)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .smp_we(smp_we), .smp_zero(smp_zero),
    .smp_waddr(smp_waddr), .smp_raddr(smp_raddr), .coef_addr(coef_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy)
  );

  fir_mac_sequencer #(.TAPS(5), .AW(3), .MAC_LAT(1)) dut_b (
    .CLK(CLK), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .smp_we(smp_we_b), .smp_zero(smp_zero_b),
    .smp_waddr(smp_waddr_b), .smp_raddr(smp_raddr_b), .coef_addr(coef_addr_b),
    .acc_clr(acc_clr_b), .acc_en(acc_en_b), .busy(busy_b)
  );

  typedef struct {
    int iv; int ordy; int we; int waddr; int raddr; int coef;
    int en; int clr; int ov; int ir;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  vec_t tv [18];
  int   wr [9];
  int   rd2 [8];
  int   cf2 [8];
  int   acc_cyc [9];
  int   wr_b [2];
  int   rd_b [2][5];

  initial begin
    int acc, widx, mac_left, ov_cnt, clr_cnt, zero_cnt, bad, seen_ov;

    // t0 = row 0; sample written to slot 0, newest = 0
    tv[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 1, 7, 1, 0, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 1, 6, 2, 1, 1, 0, 0};
    tv[4]  = '{0, 0, 0, 1, 5, 3, 1, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 1, 4, 4, 1, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 1, 3, 5, 1, 0, 0, 0};
    tv[7]  = '{0, 0, 0, 1, 2, 6, 1, 0, 0, 0};
    tv[8]  = '{0, 0, 0, 1, 1, 7, 1, 0, 0, 0};
    tv[9]  = '{0, 0, 0, 1, 1, 7, 1, 0, 0, 0};
    tv[10] = '{0, 0, 0, 1, 1, 7, 1, 0, 0, 0};
    tv[11] = '{1, 0, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[12] = '{1, 0, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[13] = '{0, 0, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[14] = '{1, 0, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[15] = '{0, 0, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[16] = '{0, 1, 0, 1, 1, 7, 0, 0, 1, 0};
    tv[17] = '{0, 0, 0, 1, 1, 7, 0, 0, 0, 1};

    rst = 1; in_valid = 0; out_ready = 0;
    rst_b = 1; in_valid_b = 0; out_ready_b = 0;

    // Reset state and clear sweep
    step; step;
    chk("rst_smp_we", smp_we, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_we[%0d]", i), smp_we, 1);
      chk($sformatf("clr_zero[%0d]", i), smp_zero, 1);
      chk($sformatf("clr_waddr[%0d]", i), smp_waddr, i);
      chk($sformatf("clr_in_ready[%0d]", i), in_ready, 0);
      step;
    end
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // First sample plus HOLD backpressure, one table row per cycle
    for (int r = 0; r < 18; r++) begin
      in_valid  = tv[r].iv[0];
      out_ready = tv[r].ordy[0];
      #1;
      chk($sformatf("tv[%0d].smp_we", r), smp_we, tv[r].we);
      chk($sformatf("tv[%0d].smp_waddr", r), smp_waddr, tv[r].waddr);
      chk($sformatf("tv[%0d].smp_raddr", r), smp_raddr, tv[r].raddr);
      chk($sformatf("tv[%0d].coef_addr", r), coef_addr, tv[r].coef);
      chk($sformatf("tv[%0d].acc_en", r), acc_en, tv[r].en);
      chk($sformatf("tv[%0d].acc_clr", r), acc_clr, tv[r].clr);
      chk($sformatf("tv[%0d].out_valid", r), out_valid, tv[r].ov);
      chk($sformatf("tv[%0d].in_ready", r), in_ready, tv[r].ir);
      if (r == 0) chk("t0_smp_zero", smp_zero, 0);
      step;
    end
    in_valid = 0; out_ready = 0;

    // Reset in the middle of a sample: strobes dropped, sweep repeats, no result
    in_valid = 1;
    #1;
    chk("abort_accept", smp_we & in_ready, 1);
    chk("abort_waddr", smp_waddr, 1);
    step;
    in_valid = 0;
    step; step;
    chk("abort_t3_acc_clr", acc_clr, 1);
    step;
    chk("abort_t4_acc_en", acc_en, 1);
    rst = 1;
    step;
    rst = 0;
    out_ready = 1;
    #1;
    chk("abort_acc_en_after", acc_en, 0);
    seen_ov = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_clr_waddr[%0d]", i), smp_waddr, i);
      chk($sformatf("abort_clr_zero[%0d]", i), smp_we & smp_zero, 1);
      if (out_valid || acc_en) seen_ov++;
      step;
    end
    chk("abort_no_result", seen_ov, 0);
    chk("abort_idle_wptr", smp_waddr, 0);
    chk("abort_idle_ready", in_ready, 1);

    // Nine back-to-back samples, downstream always ready
    acc = 0; widx = 0; mac_left = 0; ov_cnt = 0; clr_cnt = 0;
    for (int c = 0; c < 9 * 12 + 10; c++) begin
      in_valid = (acc < 9);
      #1;
      if (mac_left > 0) begin
        if (acc == 2) begin
          rd2[8 - mac_left] = smp_raddr;
          cf2[8 - mac_left] = coef_addr;
        end
        mac_left--;
      end
      if (smp_we && !smp_zero) begin
        if (widx < 9) wr[widx] = smp_waddr;
        widx++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[acc] = c;
        acc++;
        mac_left = 8;
      end
      if (out_valid) ov_cnt++;
      if (acc_clr) clr_cnt++;
      step;
    end
    in_valid = 0;
    chk("b2b_accepts", acc, 9);
    chk("b2b_writes", widx, 9);
    for (int i = 0; i < 9 && i < widx; i++)
      chk($sformatf("b2b_waddr[%0d]", i), wr[i], i % 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_s2_raddr[%0d]", i), rd2[i], (9 - i) % 8);
      chk($sformatf("b2b_s2_coef[%0d]", i), cf2[i], i);
    end
    if (acc >= 2) chk("b2b_period", acc_cyc[1] - acc_cyc[0], 12);
    chk("b2b_results", ov_cnt, 9);
    chk("b2b_acc_clr", clr_cnt, 9);

    // TAPS=5 instance: wrap at 5, never address slots 5..7
    step;
    rst_b = 0;
    out_ready_b = 1;
    acc = 0; widx = 0; mac_left = 0; ov_cnt = 0; zero_cnt = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid_b = (acc < 2);
      #1;
      if (mac_left > 0) begin
        rd_b[acc - 1][5 - mac_left] = smp_raddr_b;
        mac_left--;
      end
      if (smp_we_b && smp_zero_b) zero_cnt++;
      if (smp_we_b && !smp_zero_b) begin
        if (widx < 2) wr_b[widx] = smp_waddr_b;
        widx++;
      end
      if (in_valid_b && in_ready_b) begin
        acc++;
        mac_left = 5;
      end
      if (out_valid_b) ov_cnt++;
      if (smp_waddr_b > 3'd4 || smp_raddr_b > 3'd4 || coef_addr_b > 3'd4) bad++;
      step;
    end
    in_valid_b = 0;
    chk("t5_clear_cycles", zero_cnt, 5);
    chk("t5_accepts", acc, 2);
    chk("t5_writes", widx, 2);
    if (widx >= 2) begin
      chk("t5_waddr0", wr_b[0], 0);
      chk("t5_waddr1", wr_b[1], 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_s1_raddr[%0d]", i), rd_b[0][i], (5 - i) % 5);
      chk($sformatf("t5_s2_raddr[%0d]", i), rd_b[1][i], (6 - i) % 5);
    end
    chk("t5_results", ov_cnt, 2);
    chk("t5_addr_range", bad, 0);
    chk("t5_idle", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
